// File: rtl/cam_slice_pkg.sv
// -----------------------------------------------------------------------------
// cam_slice_pkg
// Shared types for the sliced CAM: command opcodes, update FSM states and the
// slice-count helper used to size the transposed match tables.
// No ports (package).
// -----------------------------------------------------------------------------
package cam_slice_pkg;

   typedef enum logic [1:0] {
      OP_SEARCH     = 2'b00,
      OP_WRITE      = 2'b01,
      OP_INVALIDATE = 2'b10,
      OP_FLUSH      = 2'b11
   } cam_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_CLR  = 2'b01,
      ST_SET  = 2'b10
   } cam_state_e;

   function automatic int calc_num_slices(input int width, input int slice_bits);
      return width / slice_bits;
   endfunction

endpackage

// File: rtl/cam_prio_enc.sv
// -----------------------------------------------------------------------------
// cam_prio_enc
// Reduces a per-entry match vector to hit / multi-hit flags and the lowest
// matching index. With CAM_SLICE_HIT_CNT_EN defined it also produces the
// popcount of the vector.
// Ports:
//   i_vec   in   DEPTH   match vector
//   o_hit   out  1       any bit set
//   o_mhit  out  1       two or more bits set
//   o_addr  out  AW      lowest set index, 0 when no bit set
//   o_cnt   out  AW+1    number of set bits (CAM_SLICE_HIT_CNT_EN only)
// -----------------------------------------------------------------------------
module cam_prio_enc #(
   parameter int DEPTH = 64,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic [DEPTH-1:0] i_vec,
`ifdef CAM_SLICE_HIT_CNT_EN
   output logic [AW:0]      o_cnt,
`endif
   output logic             o_hit,
   output logic             o_mhit,
   output logic [AW-1:0]    o_addr
);

   always_comb begin
      o_addr = '0;
      // scan downwards so the lowest set index is the last one written
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (i_vec[i]) o_addr = AW'(i);
      end
   end

   assign o_hit  = |i_vec;
   // clearing the lowest set bit leaves something only if two or more were set
   assign o_mhit = |(i_vec & (i_vec - DEPTH'(1)));

`ifdef CAM_SLICE_HIT_CNT_EN
   always_comb begin
      o_cnt = '0;
      for (int i = 0; i < DEPTH; i++) begin
         o_cnt = o_cnt + {{AW{1'b0}}, i_vec[i]};
      end
   end
`endif

endmodule

// File: rtl/cam_slice_table.sv
// -----------------------------------------------------------------------------
// cam_slice_table
// Pipelined binary CAM. The key is cut into SLICE_BITS-wide slices; each slice
// owns a transposed one-hot table (row = slice value, column = entry), so a
// search is one row read per slice followed by an AND across slices. Writes
// run a two-phase update: CLR removes the entry's old key bits (tracked in a
// shadow key array), SET installs the new ones.
// Optional feature macro: CAM_SLICE_HIT_CNT_EN (adds rsp_hit_cnt popcount).
// Ports:
//   clk, sys_rstn              clock, async active-low reset
//   cmd_valid/cmd_ready        command handshake (ready only in IDLE)
//   cmd_op                     00 SEARCH, 01 WRITE, 10 INVALIDATE, 11 FLUSH
//   cmd_addr, cmd_key          entry address / key
//   rsp_valid                  one pulse per SEARCH, 2 cycles after acceptance
//   rsp_hit, rsp_mhit          any / multiple valid matches
//   rsp_addr, rsp_match        lowest matching entry, valid-masked match vector
//   rsp_hit_cnt                popcount of rsp_match (CAM_SLICE_HIT_CNT_EN)
//   busy                       update in progress or searches in flight
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | accepting commands; SEARCH/INVALIDATE/FLUSH complete here
// ST_CLR  | clear entry's old shadow-key bits in every slice table
// ST_SET  | set new key bits, update shadow key, mark entry valid
// -----------------------------------------------------------------------------
module cam_slice_table
   import cam_slice_pkg::*;
#(
   parameter int CAM_DEPTH      = 64,
   parameter int CAM_WIDTH      = 32,
   parameter int SLICE_BITS     = 4,
   parameter int CAM_ADDR_WIDTH = $clog2(CAM_DEPTH)
) (
   input  logic                      clk,
   input  logic                      sys_rstn,
   input  logic                      cmd_valid,
   output logic                      cmd_ready,
   input  logic [1:0]                cmd_op,
   input  logic [CAM_ADDR_WIDTH-1:0] cmd_addr,
   input  logic [CAM_WIDTH-1:0]      cmd_key,
   output logic                      rsp_valid,
   output logic                      rsp_hit,
   output logic                      rsp_mhit,
   output logic [CAM_ADDR_WIDTH-1:0] rsp_addr,
   output logic [CAM_DEPTH-1:0]      rsp_match,
`ifdef CAM_SLICE_HIT_CNT_EN
   output logic [CAM_ADDR_WIDTH:0]   rsp_hit_cnt,
`endif
   output logic                      busy
);

   localparam int NUM_SLICES = calc_num_slices(CAM_WIDTH, SLICE_BITS);
   localparam int NUM_ROWS   = 1 << SLICE_BITS;

   cam_state_e                r_state;
   logic [CAM_DEPTH-1:0]      r_slice_tbl [NUM_SLICES][NUM_ROWS];
   logic [CAM_WIDTH-1:0]      r_shadow_key [CAM_DEPTH];
   logic [CAM_DEPTH-1:0]      r_valid;
   logic [CAM_ADDR_WIDTH-1:0] r_wr_addr;
   logic [CAM_WIDTH-1:0]      r_wr_key;

   logic                      r_s1_vld;
   logic [CAM_DEPTH-1:0]      r_s1_rows [NUM_SLICES];
   logic [CAM_DEPTH-1:0]      r_s1_valid;

   logic                      w_accept;
   logic                      w_search;
   cam_op_e                   w_op;
   logic [CAM_WIDTH-1:0]      w_old_key;
   logic [SLICE_BITS-1:0]     w_srch_row [NUM_SLICES];
   logic [SLICE_BITS-1:0]     w_old_row  [NUM_SLICES];
   logic [SLICE_BITS-1:0]     w_new_row  [NUM_SLICES];
   logic [CAM_DEPTH-1:0]      w_match;
   logic                      w_hit;
   logic                      w_mhit;
   logic [CAM_ADDR_WIDTH-1:0] w_addr;
`ifdef CAM_SLICE_HIT_CNT_EN
   logic [CAM_ADDR_WIDTH:0]   w_cnt;
`endif

   assign cmd_ready = (r_state == ST_IDLE);
   assign w_accept  = cmd_valid & cmd_ready;
   assign w_op      = cam_op_e'(cmd_op);
   assign w_search  = w_accept & (w_op == OP_SEARCH);
   assign w_old_key = r_shadow_key[r_wr_addr];
   assign busy      = (r_state != ST_IDLE) | r_s1_vld | rsp_valid;

   always_comb begin
      for (int s = 0; s < NUM_SLICES; s++) begin
         w_srch_row[s] = cmd_key[s*SLICE_BITS +: SLICE_BITS];
         w_old_row[s]  = w_old_key[s*SLICE_BITS +: SLICE_BITS];
         w_new_row[s]  = r_wr_key[s*SLICE_BITS +: SLICE_BITS];
      end
   end

   // update FSM and all table storage
   always_ff @(posedge clk or negedge sys_rstn) begin
      if (!sys_rstn) begin
         r_state   <= ST_IDLE;
         r_valid   <= '0;
         r_wr_addr <= '0;
         r_wr_key  <= '0;
         for (int s = 0; s < NUM_SLICES; s++)
            for (int v = 0; v < NUM_ROWS; v++)
               r_slice_tbl[s][v] <= '0;
         for (int e = 0; e < CAM_DEPTH; e++)
            r_shadow_key[e] <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  case (w_op)
                     OP_WRITE: begin
                        r_wr_addr <= cmd_addr;
                        r_wr_key  <= cmd_key;
                        r_state   <= ST_CLR;
                     end
                     OP_INVALIDATE: r_valid[cmd_addr] <= 1'b0;
                     OP_FLUSH: begin
                        r_valid <= '0;
                        for (int s = 0; s < NUM_SLICES; s++)
                           for (int v = 0; v < NUM_ROWS; v++)
                              r_slice_tbl[s][v] <= '0;
                        for (int e = 0; e < CAM_DEPTH; e++)
                           r_shadow_key[e] <= '0;
                     end
                     default: ;
                  endcase
               end
            end
            ST_CLR: begin
               // done even for invalid entries so stale bits never survive a rewrite
               for (int s = 0; s < NUM_SLICES; s++)
                  r_slice_tbl[s][w_old_row[s]][r_wr_addr] <= 1'b0;
               r_state <= ST_SET;
            end
            ST_SET: begin
               for (int s = 0; s < NUM_SLICES; s++)
                  r_slice_tbl[s][w_new_row[s]][r_wr_addr] <= 1'b1;
               r_shadow_key[r_wr_addr] <= r_wr_key;
               r_valid[r_wr_addr]      <= 1'b1;
               r_state                 <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // search stage 1: snapshot the addressed row of every slice plus valid
   always_ff @(posedge clk or negedge sys_rstn) begin
      if (!sys_rstn) begin
         r_s1_vld   <= 1'b0;
         r_s1_valid <= '0;
         for (int s = 0; s < NUM_SLICES; s++)
            r_s1_rows[s] <= '0;
      end else begin
         r_s1_vld <= w_search;
         if (w_search) begin
            r_s1_valid <= r_valid;
            for (int s = 0; s < NUM_SLICES; s++)
               r_s1_rows[s] <= r_slice_tbl[s][w_srch_row[s]];
         end
      end
   end

   always_comb begin
      w_match = r_s1_valid;
      for (int s = 0; s < NUM_SLICES; s++)
         w_match = w_match & r_s1_rows[s];
   end

   cam_prio_enc #(
      .DEPTH (CAM_DEPTH),
      .AW    (CAM_ADDR_WIDTH)
   ) u_prio_enc (
      .i_vec  (w_match),
`ifdef CAM_SLICE_HIT_CNT_EN
      .o_cnt  (w_cnt),
`endif
      .o_hit  (w_hit),
      .o_mhit (w_mhit),
      .o_addr (w_addr)
   );

   // search stage 2: register the response; fields hold between pulses
   always_ff @(posedge clk or negedge sys_rstn) begin
      if (!sys_rstn) begin
         rsp_valid   <= 1'b0;
         rsp_hit     <= 1'b0;
         rsp_mhit    <= 1'b0;
         rsp_addr    <= '0;
         rsp_match   <= '0;
`ifdef CAM_SLICE_HIT_CNT_EN
         rsp_hit_cnt <= '0;
`endif
      end else begin
         rsp_valid <= r_s1_vld;
         if (r_s1_vld) begin
            rsp_hit     <= w_hit;
            rsp_mhit    <= w_mhit;
            rsp_addr    <= w_addr;
            rsp_match   <= w_match;
`ifdef CAM_SLICE_HIT_CNT_EN
            rsp_hit_cnt <= w_cnt;
`endif
         end
      end
   end

endmodule

// File: tb/tb_cam_slice_table.sv
module tb_cam_slice_table;

   localparam int DEPTH = 64;
   localparam int WIDTH = 32;
   localparam int AW    = 6;

   logic             clk = 1'b0;
   logic             sys_rstn = 1'b0;
   logic             cmd_valid = 1'b0;
   logic [1:0]       cmd_op = 2'b00;
   logic [AW-1:0]    cmd_addr = '0;
   logic [WIDTH-1:0] cmd_key = '0;
   logic             cmd_ready;
   logic             rsp_valid, rsp_hit, rsp_mhit, busy;
   logic [AW-1:0]    rsp_addr;
   logic [DEPTH-1:0] rsp_match;
`ifdef CAM_SLICE_HIT_CNT_EN
   logic [AW:0]      rsp_hit_cnt;
`endif

   cam_slice_table #(
      .CAM_DEPTH(DEPTH), .CAM_WIDTH(WIDTH), .SLICE_BITS(4), .CAM_ADDR_WIDTH(AW)
   ) dut (
      .clk(clk), .sys_rstn(sys_rstn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_addr(cmd_addr), .cmd_key(cmd_key),
      .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_mhit(rsp_mhit),
      .rsp_addr(rsp_addr), .rsp_match(rsp_match),
`ifdef CAM_SLICE_HIT_CNT_EN
      .rsp_hit_cnt(rsp_hit_cnt),
`endif
      .busy(busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // behavioural model: plain key/valid arrays, expected responses queued by due edge
   typedef struct {
      int               due;
      logic [DEPTH-1:0] match;
   } exp_t;

   logic [WIDTH-1:0] m_key [DEPTH];
   logic [DEPTH-1:0] m_valid = '0;
   exp_t             q[$];
   int               last_wr = -100;
   bit               in_rst = 1'b1;

   int               n_cmp = 0;
   int               n_fail = 0;
   int               n_rsp = 0;
   logic             last_hit, last_mhit;
   logic [AW-1:0]    last_addr;
   logic [DEPTH-1:0] last_match;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [DEPTH-1:0] model_match(input logic [WIDTH-1:0] key);
      logic [DEPTH-1:0] r;
      r = '0;
      for (int e = 0; e < DEPTH; e++)
         if (m_valid[e] && m_key[e] == key) r[e] = 1'b1;
      return r;
   endfunction

   function automatic int lowest(input logic [DEPTH-1:0] m);
      for (int e = 0; e < DEPTH; e++)
         if (m[e]) return e;
      return 0;
   endfunction

   task automatic model_clear();
      m_valid = '0;
      for (int e = 0; e < DEPTH; e++) m_key[e] = '0;
   endtask

   always @(negedge clk) begin : compare
      int   k;
      exp_t e;
      bit   wr_pend;
      k = cyc;
      if (in_rst) begin
         check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
         check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
         check("rst_busy", 64'(busy), 64'd0);
         check("rst_rsp_match", 64'(rsp_match), 64'd0);
         check("rst_rsp_addr_hit", {56'd0, rsp_hit, rsp_mhit, rsp_addr}, 64'd0);
      end else begin
         wr_pend = (k - last_wr) <= 1;
         check("cmd_ready", 64'(cmd_ready), 64'(!wr_pend));
         check("busy", 64'(busy), 64'(wr_pend || q.size() > 0));
         if (q.size() > 0 && q[0].due == k) begin
            e = q.pop_front();
            n_rsp++;
            check("rsp_valid", 64'(rsp_valid), 64'd1);
            check("rsp_match", 64'(rsp_match), 64'(e.match));
            check("rsp_hit", 64'(rsp_hit), 64'(e.match != 0));
            check("rsp_mhit", 64'(rsp_mhit), 64'($countones(e.match) >= 2));
            check("rsp_addr", 64'(rsp_addr), 64'(lowest(e.match)));
`ifdef CAM_SLICE_HIT_CNT_EN
            check("rsp_hit_cnt", 64'(rsp_hit_cnt), 64'($countones(e.match)));
`endif
            last_hit = rsp_hit; last_mhit = rsp_mhit;
            last_addr = rsp_addr; last_match = rsp_match;
         end else begin
            check("rsp_valid_idle", 64'(rsp_valid), 64'd0);
         end
      end
   end

   task automatic apply_model(input logic [1:0] op, input int addr, input logic [WIDTH-1:0] key,
                              input int acc);
      exp_t e;
      case (op)
         2'b00: begin e.due = acc + 1; e.match = model_match(key); q.push_back(e); end
         2'b01: begin m_key[addr] = key; m_valid[addr] = 1'b1; last_wr = acc; end
         2'b10: m_valid[addr] = 1'b0;
         default: model_clear();
      endcase
   endtask

   task automatic do_cmd(input logic [1:0] op, input int addr, input logic [WIDTH-1:0] key);
      bit rdy;
      int k;
      int guard;
      cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr[AW-1:0]; cmd_key = key;
      guard = 0;
      forever begin
         @(negedge clk); rdy = cmd_ready; k = cyc;
         @(posedge clk);
         if (rdy) break;
         guard++;
         if (guard > 10) begin
            n_cmp++; n_fail++;
            $display("FAIL accept_timeout: cmd_ready stayed 0, expected 1 within 10 cycles");
            break;
         end
      end
      if (rdy) apply_model(op, addr, key, k + 1);
      #1;
      cmd_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int n);
      sys_rstn = 1'b0; in_rst = 1'b1;
      model_clear(); q.delete(); last_wr = -100;
      idle(n);
      sys_rstn = 1'b1; in_rst = 1'b0;
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      logic [WIDTH-1:0] pool [4];
      int r0;
      model_clear();
      idle(3);
      sys_rstn = 1'b1; in_rst = 1'b0;
      idle(1);

      // single entry hit
      do_cmd(2'b01, 5, 32'hDEADBEEF);
      do_cmd(2'b00, 0, 32'hDEADBEEF);
      idle(3);
      check("t1_hit", 64'(last_hit), 64'd1);
      check("t1_mhit", 64'(last_mhit), 64'd0);
      check("t1_addr", 64'(last_addr), 64'd5);
      check("t1_match", 64'(last_match), 64'h20);

      // multi-hit
      do_cmd(2'b01, 3, 32'h12345678);
      do_cmd(2'b01, 9, 32'h12345678);
      do_cmd(2'b00, 0, 32'h12345678);
      idle(3);
      check("t2_mhit", 64'(last_mhit), 64'd1);
      check("t2_addr", 64'(last_addr), 64'd3);
      check("t2_match", 64'(last_match), 64'h208);

      // overwrite
      do_cmd(2'b01, 7, 32'hA);
      do_cmd(2'b01, 7, 32'hB);
      do_cmd(2'b00, 0, 32'hA);
      idle(3);
      check("t3_old_miss", {last_hit, last_addr, last_match}, 64'd0);
      do_cmd(2'b00, 0, 32'hB);
      idle(3);
      check("t3_new_addr", 64'(last_addr), 64'd7);
      check("t3_new_match", 64'(last_match), 64'h80);

      // invalidate, then rewrite removes stale bits
      do_cmd(2'b01, 2, 32'hC);
      do_cmd(2'b10, 2, 32'h0);
      do_cmd(2'b00, 0, 32'hC);
      idle(3);
      check("t4_inval_miss", 64'(last_hit), 64'd0);
      do_cmd(2'b01, 2, 32'hD);
      do_cmd(2'b00, 0, 32'hC);
      idle(3);
      check("t4_stale_miss", 64'(last_match), 64'd0);

      // back-to-back searches then flush
      r0 = n_rsp;
      do_cmd(2'b00, 0, 32'hDEADBEEF);
      do_cmd(2'b00, 0, 32'h12345678);
      do_cmd(2'b00, 0, 32'hB);
      do_cmd(2'b00, 0, 32'hD);
      do_cmd(2'b11, 0, 32'h0);
      do_cmd(2'b00, 0, 32'hDEADBEEF);
      idle(3);
      check("t5_rsp_count", 64'(n_rsp - r0), 64'd5);
      check("t5_post_flush_miss", 64'(last_hit), 64'd0);

      // reset during CLR
      do_cmd(2'b01, 4, 32'h12345678);
      do_reset(2);
      idle(1);
      check("t6_ready", 64'(cmd_ready), 64'd1);
      check("t6_outputs", {rsp_valid, rsp_hit, rsp_mhit, busy, rsp_addr}, 64'd0);
      check("t6_match", 64'(rsp_match), 64'd0);
      do_cmd(2'b00, 0, 32'h12345678);
      idle(3);
      check("t6_miss", 64'(last_hit), 64'd0);

      // reset with a search in flight: its response must never appear
      do_cmd(2'b01, 1, 32'h55);
      do_cmd(2'b00, 0, 32'h55);
      do_reset(2);
      idle(3);

      // randomized traffic
      pool[0] = 32'hCAFE0001; pool[1] = 32'hCAFE0011;
      pool[2] = 32'h0BADF00D; pool[3] = 32'h1BADF00D;
      for (int i = 0; i < 400; i++) begin
         int sel;
         sel = $urandom_range(0, 99);
         if (sel < 50)      do_cmd(2'b00, 0, pool[$urandom_range(0, 3)]);
         else if (sel < 80) do_cmd(2'b01, $urandom_range(0, 7), pool[$urandom_range(0, 3)]);
         else if (sel < 95) do_cmd(2'b10, $urandom_range(0, 7), 32'h0);
         else if (sel < 98) do_cmd(2'b11, 0, 32'h0);
         else               idle($urandom_range(1, 3));
      end
      idle(4);
      check("queue_drained", 64'(q.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/cam_slice_table.md
# cam_slice_table

Pipelined, parametrised binary CAM that generalises the single-port BRAM CAM. The key is split into `SLICE_BITS`-wide slices, each held as a transposed one-hot match table, so a search costs one table read per slice. It accepts commands over a valid/ready handshake, services back-to-back searches at one per cycle, and runs a two-phase clear/set update FSM for writes. It sits between the lookup front-end and the hit consumers in place of the fixed-size CAM macro.

## Interface
- `CAM_DEPTH`, 64: number of entries.
- `CAM_WIDTH`, 32: key width.
- `SLICE_BITS`, 4: bits per slice. Must divide `CAM_WIDTH`; `NUM_SLICES = CAM_WIDTH/SLICE_BITS`.
- `CAM_ADDR_WIDTH`, `$clog2(CAM_DEPTH)`: entry address width.
- `clk`  in  1  clock.
- `sys_rstn`  in  1  reset, asynchronous, active-low.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  command accepted when `cmd_valid & cmd_ready`.
- `cmd_op`  in  2  command opcode: 00 SEARCH, 01 WRITE, 10 INVALIDATE, 11 FLUSH.
- `cmd_addr`  in  `CAM_ADDR_WIDTH`  entry for WRITE/INVALIDATE.
- `cmd_key`  in  `CAM_WIDTH`  key for SEARCH/WRITE.
- `rsp_valid`  out  1  one-cycle pulse per SEARCH; there is no backpressure.
- `rsp_hit`  out  1  at least one valid entry matched.
- `rsp_mhit`  out  1  two or more valid entries matched.
- `rsp_addr`  out  `CAM_ADDR_WIDTH`  lowest matching address; 0 on miss.
- `rsp_match`  out  `CAM_DEPTH`  per-entry match vector, masked by valid.
- `busy`  out  1  FSM not in IDLE, or the search pipeline is non-empty.

## Operation
- Storage:
  - `slice_tbl[s][v]` holds `CAM_DEPTH` bits.
  - `shadow_key[CAM_DEPTH]` holds each entry's last written key.
  - `valid[CAM_DEPTH]` holds entry valid bits.
  - All storage is cleared by reset and by FLUSH.
- FSM states: IDLE, CLR, SET.
  - `cmd_ready = (state == IDLE)`.
- SEARCH, accepted in IDLE:
  - Stage 1 registers `slice_tbl[s][key_s]` for every slice, plus a snapshot of `valid`.
  - Stage 2 ANDs all slice rows with the valid snapshot, then registers the result into `rsp_match`, the priority-encoded `rsp_addr`, `rsp_hit` and `rsp_mhit`.
  - The state stays IDLE, so a new command can be accepted every cycle.
- WRITE:
  - On acceptance: latch addr/key, go IDLE→CLR.
  - CLR: for each slice, clear bit `addr` in `slice_tbl[s][shadow_key[addr]_s]`. This happens regardless of `valid`, so stale bits from an invalidated entry are always removed. Go CLR→SET.
  - SET: set bit `addr` in `slice_tbl[s][key_s]`, write `shadow_key[addr] = key` and `valid[addr] = 1`. Go SET→IDLE.
- INVALIDATE: `valid[addr] = 0` on the acceptance edge; the state stays IDLE.
- FLUSH: clears all slice tables, shadow keys and valid bits on the acceptance edge; the state stays IDLE.
- Ordering:
  - Every SEARCH observes the table exactly as it stood at its acceptance, including all earlier accepted commands and none of the later ones.
  - In-flight searches complete with their pre-update snapshot.

## Timing
- Reset values:
  - `cmd_ready = 1`.
  - `rsp_valid`, `rsp_hit`, `rsp_mhit`, `busy` = 0.
  - `rsp_addr = 0`, `rsp_match = 0`.
  - FSM in IDLE.
- SEARCH latency: `rsp_valid` is asserted exactly 2 cycles after the acceptance edge. Throughput is 1 per cycle.
- WRITE: `cmd_ready` is low for 2 cycles after acceptance. The next command can be accepted on the 3rd cycle.
- INVALIDATE and FLUSH take 1 cycle. A SEARCH accepted on the next cycle sees the effect.
- Reset asserted mid-WRITE or mid-search:
  - The FSM returns to IDLE and the pipeline empties.
  - No `rsp_valid` is produced for the lost search.
  - The partially updated entry is discarded, because all storage clears.
- `rsp_mhit` implies `rsp_hit`. On a miss, `rsp_addr = 0` and `rsp_match = 0`.

## Configuration
- `CAM_SLICE_HIT_CNT_EN` defined:
  - Adds output `rsp_hit_cnt`, width `CAM_ADDR_WIDTH+1`: the popcount of `rsp_match`.
  - It is registered in stage 2 alongside the other response fields and resets to 0.
- `CAM_SLICE_HIT_CNT_EN` undefined: the port and the popcount logic are absent. All other behaviour is identical.

## Structure
- Package `cam_slice_pkg` contains:
  - `cam_op_e` opcode enum.
  - `cam_state_e` enum: IDLE/CLR/SET.
  - Function for the `NUM_SLICES` computation.
- Sub-module `cam_prio_enc` takes a `CAM_DEPTH` vector and produces:
  - `hit`, `mhit`, lowest-index `addr`.
  - Optional popcount, under the macro.
- Slice tables are inferred as a register array inside the top module.

## Test plan
- Write 0xDEADBEEF at addr 5, then search 0xDEADBEEF → 2 cycles later: `rsp_hit=1`, `rsp_mhit=0`, `rsp_addr=5`, `rsp_match` has only bit 5 set.
- Write 0x12345678 at addr 3 and at addr 9, then search it → `rsp_hit=1`, `rsp_mhit=1`, `rsp_addr=3`, bits 3 and 9 set; hit count 2 with the macro defined.
- Write 0xA at addr 7, overwrite addr 7 with 0xB, then search 0xA → miss; search 0xB → hit at addr 7.
- Write 0xC at addr 2, INVALIDATE addr 2, search 0xC → miss; rewrite addr 2 with 0xD, search 0xC → miss (stale bits cleared).
- Four back-to-back searches, with a FLUSH accepted right after them → four `rsp_valid` pulses on consecutive cycles, all showing the pre-flush results; a following search misses.
- Deassert `sys_rstn` during CLR → `cmd_ready=1` and all outputs 0 after release; a following search misses.
